// File: rtl/clk_div_gen_pkg.sv
// Shared types and helpers for the clk_div_gen divider block.
package clk_div_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int CNT_W_MAX = 32;

    localparam logic [CNT_W_MAX-1:0] CNT_ZERO = {CNT_W_MAX{1'b0}};
    localparam logic [CNT_W_MAX-1:0] CNT_ONE  = {{(CNT_W_MAX-1){1'b0}}, 1'b1};

    typedef enum logic {
        LOCK_WAIT   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_e;

    // Channel configuration is carried at the widest supported counter width.
    typedef struct packed {
        logic [CNT_W_MAX-1:0] div;
        logic [CNT_W_MAX-1:0] phase;
    } ch_cfg_t;

    // Number of high cycles per period: ceil(div/2), so odd ratios get the extra high cycle.
    function automatic logic [CNT_W_MAX-1:0] high_len(input logic [CNT_W_MAX-1:0] div);
        logic [CNT_W_MAX:0] sum_v;
        sum_v = {1'b0, div} + {1'b0, CNT_ONE};
        return sum_v[CNT_W_MAX:1];
    endfunction

    function automatic logic cfg_valid(input logic [CNT_W_MAX-1:0] div,
                                       input logic [CNT_W_MAX-1:0] phase);
        return (div == CNT_ZERO) || (phase < div);
    endfunction

endpackage

// File: rtl/clk_div_gen_ch.sv
// One divider channel: config registers, wrapping counter and registered enable/square decode.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int DIV_INIT = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    run,
    input  logic    restart,
    input  logic    cfg_we,
    input  ch_cfg_t cfg_in,
    output logic    clk_en,
    output logic    clk_out
);

    ch_cfg_t              cfg_r;
    ch_cfg_t              cfg_nxt_s;
    logic [CNT_W_MAX-1:0] cnt_r;
    logic [CNT_W_MAX-1:0] cnt_nxt_s;
    logic                 en_r;
    logic                 out_r;
    logic                 en_nxt_s;
    logic                 out_nxt_s;

    // Outputs are decoded from the count the next cycle will present, so they can be registered.
    always_comb begin
        cfg_nxt_s = cfg_r;
        cnt_nxt_s = cnt_r;
        en_nxt_s  = 1'b0;
        out_nxt_s = 1'b0;
        if (cfg_we) begin
            cfg_nxt_s = cfg_in;
        end else begin
            cfg_nxt_s = cfg_r;
        end
        if (!run) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (restart) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (cfg_r.div == CNT_ZERO) begin
            cnt_nxt_s = cnt_r;
        end else if (cnt_r == (cfg_r.div - CNT_ONE)) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
        if (run && (cfg_nxt_s.div != CNT_ZERO)) begin
            en_nxt_s  = (cnt_nxt_s == cfg_nxt_s.phase);
            out_nxt_s = (cnt_nxt_s < high_len(cfg_nxt_s.div));
        end else begin
            en_nxt_s  = 1'b0;
            out_nxt_s = 1'b0;
        end
    end

    // Channel state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_r.div   <= CNT_W_MAX'(DIV_INIT);
            cfg_r.phase <= CNT_ZERO;
            cnt_r       <= CNT_ZERO;
            en_r        <= 1'b0;
            out_r       <= 1'b0;
        end else begin
            cfg_r <= cfg_nxt_s;
            cnt_r <= cnt_nxt_s;
            en_r  <= en_nxt_s;
            out_r <= out_nxt_s;
        end
    end

    assign clk_en  = en_r;
    assign clk_out = out_r;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable / divided-clock generator with lock sequencer and gated reset.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_INIT    = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                                       sys_clk,
    input  logic                                       sys_rst_n,
    input  logic                                       cfg_wr,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                           cfg_div,
    input  logic [CNT_W-1:0]                           cfg_phase,
    input  logic                                       sync_start,
    output logic                                       cfg_err,
    output logic                                       locked,
    output logic                                       rst_out_n,
    output logic [NUM_CH-1:0]                          clk_en,
    output logic [NUM_CH-1:0]                          clk_out
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LC_W = $clog2(LOCK_CYCLES);

    lock_state_e state_r;
    logic [LC_W-1:0] lock_cnt_r;
    logic        locked_r;
    logic        rst_out_n_r;
    logic        cfg_err_r;
    logic        start_s;
    logic        running_s;
    logic        active_s;
    logic        sync_s;
    logic        ch_in_range_s;
    logic        wr_ok_s;
    logic        wr_bad_s;
    ch_cfg_t     wr_cfg_s;

    // Sequencer status and write validation.
    always_comb begin
        running_s     = (state_r == LOCK_LOCKED);
        start_s       = (state_r == LOCK_WAIT) && (lock_cnt_r == LC_W'(LOCK_CYCLES - 1));
        active_s      = running_s || start_s;
        sync_s        = sync_start && running_s;
        ch_in_range_s = (int'(cfg_ch) < NUM_CH);
        wr_cfg_s.div  = CNT_W_MAX'(cfg_div);
        if (cfg_div == {CNT_W{1'b0}}) begin
            wr_cfg_s.phase = CNT_ZERO;
        end else begin
            wr_cfg_s.phase = CNT_W_MAX'(cfg_phase);
        end
        wr_ok_s  = cfg_wr && ch_in_range_s && cfg_valid(wr_cfg_s.div, CNT_W_MAX'(cfg_phase));
        wr_bad_s = cfg_wr && !wr_ok_s;
    end

    // Lock sequencer: count out the lock window, then hold LOCKED until the next reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r     <= LOCK_WAIT;
            lock_cnt_r  <= {LC_W{1'b0}};
            locked_r    <= 1'b0;
            rst_out_n_r <= 1'b0;
        end else begin
            case (state_r)
                LOCK_WAIT: begin
                    if (lock_cnt_r == LC_W'(LOCK_CYCLES - 1)) begin
                        state_r     <= LOCK_LOCKED;
                        locked_r    <= 1'b1;
                        rst_out_n_r <= 1'b1;
                    end else begin
                        lock_cnt_r  <= lock_cnt_r + LC_W'(1);
                    end
                end
                LOCK_LOCKED: begin
                    locked_r    <= 1'b1;
                    rst_out_n_r <= 1'b1;
                end
                default: begin
                    state_r     <= LOCK_WAIT;
                    lock_cnt_r  <= {LC_W{1'b0}};
                    locked_r    <= 1'b0;
                    rst_out_n_r <= 1'b0;
                end
            endcase
        end
    end

    // Rejected-write strobe.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= wr_bad_s;
        end
    end

    assign locked    = locked_r;
    assign rst_out_n = rst_out_n_r;
    assign cfg_err   = cfg_err_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic we_s;
        logic restart_s;

        // A write only restarts its channel once running; before that it just preloads config.
        always_comb begin
            we_s      = wr_ok_s && (cfg_ch == CH_W'(i));
            restart_s = start_s || (running_s && (sync_s || we_s));
        end

        clk_div_ch #(
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk     (sys_clk),
            .rst_n   (sys_rst_n),
            .run     (active_s),
            .restart (restart_s),
            .cfg_we  (we_s),
            .cfg_in  (wr_cfg_s),
            .clk_en  (clk_en[i]),
            .clk_out (clk_out[i])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: a cycle-level reference model queues expected outputs, a monitor checks them.
module tb_clk_div_gen;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 16;
    localparam int DIV_INIT    = 2;
    localparam int LOCK_CYCLES = 16;

    typedef logic [2*NUM_CH+2:0] vec_t;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              cfg_wr = 1'b0;
    logic [1:0]        cfg_ch = 2'd0;
    logic [CNT_W-1:0]  cfg_div = 16'd0;
    logic [CNT_W-1:0]  cfg_phase = 16'd0;
    logic              sync_start = 1'b0;
    logic              cfg_err;
    logic              locked;
    logic              rst_out_n;
    logic [NUM_CH-1:0] clk_en;
    logic [NUM_CH-1:0] clk_out;

    int   n_vec = 0;
    int   n_mis = 0;
    vec_t exp_q[$];
    bit   pushed_any = 1'b0;

    // Reference model state: absolute cycle counts rather than wrapped counters.
    int m_cyc;
    bit m_locked;
    int m_div[NUM_CH];
    int m_ph[NUM_CH];
    int m_k[NUM_CH];

    clk_div_gen #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DIV_INIT    (DIV_INIT),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_phase  (cfg_phase),
        .sync_start (sync_start),
        .cfg_err    (cfg_err),
        .locked     (locked),
        .rst_out_n  (rst_out_n),
        .clk_en     (clk_en),
        .clk_out    (clk_out)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic model_reset();
        m_cyc    = 0;
        m_locked = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = DIV_INIT;
            m_ph[i]  = 0;
            m_k[i]   = 0;
        end
    endtask

    // Evaluate the inputs seen at this rising edge and queue what the outputs must read afterwards.
    task automatic model_step();
        bit                now_locked;
        bit                err;
        bit                rs[NUM_CH];
        logic [NUM_CH-1:0] en_v;
        logic [NUM_CH-1:0] out_v;
        int                dv;
        int                ph;
        int                ch;
        int                r;
        if (!sys_rst_n) begin
            model_reset();
            exp_q.push_back({(2*NUM_CH+3){1'b0}});
            return;
        end
        m_cyc++;
        now_locked = (m_cyc >= LOCK_CYCLES);
        err = 1'b0;
        for (int i = 0; i < NUM_CH; i++) rs[i] = 1'b0;
        if (cfg_wr) begin
            dv = int'(cfg_div);
            ph = int'(cfg_phase);
            ch = int'(cfg_ch);
            if (ch >= NUM_CH || (dv != 0 && ph >= dv)) begin
                err = 1'b1;
            end else begin
                m_div[ch] = dv;
                m_ph[ch]  = (dv == 0) ? 0 : ph;
                if (m_locked) rs[ch] = 1'b1;
            end
        end
        if (sync_start && m_locked) begin
            for (int i = 0; i < NUM_CH; i++) rs[i] = 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (now_locked && !m_locked) m_k[i] = 0;
            else if (rs[i]) m_k[i] = 0;
            else if (m_locked && m_div[i] != 0) m_k[i]++;
            if (now_locked && m_div[i] != 0) begin
                r        = m_k[i] % m_div[i];
                en_v[i]  = (r == m_ph[i]);
                out_v[i] = (r < (m_div[i] + 1) / 2);
            end else begin
                en_v[i]  = 1'b0;
                out_v[i] = 1'b0;
            end
        end
        m_locked = now_locked;
        exp_q.push_back({now_locked, now_locked, err, en_v, out_v});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge sys_clk);
            model_step();
            pushed_any = 1'b1;
        end
    end

    // Monitor: one expected vector per cycle, compared on the falling edge.
    initial begin
        vec_t e;
        vec_t a;
        forever begin
            @(negedge sys_clk);
            if (exp_q.size() == 0) begin
                if (pushed_any) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL scoreboard_empty t=%0t", $time);
                end
            end else begin
                e = exp_q.pop_front();
                if (sys_rst_n) begin
                    a = {locked, rst_out_n, cfg_err, clk_en, clk_out};
                    n_vec++;
                    if (a !== e) begin
                        n_mis++;
                        $display("FAIL outputs t=%0t got lock/rst/err/en/out=%b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
                                 $time, a[10], a[9], a[8], a[7:4], a[3:0],
                                 e[10], e[9], e[8], e[7:4], e[3:0]);
                    end
                end
            end
        end
    end

    task automatic check_zero(input string name);
        vec_t a;
        a = {locked, rst_out_n, cfg_err, clk_en, clk_out};
        n_vec++;
        if (a !== {(2*NUM_CH+3){1'b0}}) begin
            n_mis++;
            $display("FAIL %s t=%0t got %b want all zero", name, $time, a);
        end
    endtask

    task automatic drive(input bit wr, input int ch, input int dv, input int ph, input bit sy);
        @(negedge sys_clk);
        #1;
        cfg_wr     = wr;
        cfg_ch     = 2'(ch);
        cfg_div    = 16'(dv);
        cfg_phase  = 16'(ph);
        sync_start = sy;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset(input int hold, input bit check);
        @(negedge sys_clk);
        #1;
        sys_rst_n  = 1'b0;
        cfg_wr     = 1'b0;
        sync_start = 1'b0;
        #1;
        if (check) check_zero("reset_async");
        repeat (hold) @(negedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        #1;
        check_zero("reset_state");
        sys_rst_n = 1'b1;
        idle(24);
        drive(1'b1, 1, 5, 3, 1'b0);
        idle(15);
        drive(1'b1, 2, 4, 4, 1'b0);
        idle(6);
        drive(1'b1, 0, 3, 0, 1'b0);
        drive(1'b1, 3, 6, 0, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b1);
        idle(14);
        drive(1'b1, 2, 0, 7, 1'b0);
        idle(6);
        drive(1'b1, 2, 1, 0, 1'b0);
        idle(6);
        drive(1'b1, 1, 7, 2, 1'b1);
        idle(16);
        do_reset(2, 1'b1);
        drive(1'b1, 1, 3, 1, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b1);
        drive(1'b1, 0, 2, 5, 1'b0);
        idle(25);
        do_reset(3, 1'b1);
        idle(30);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset($urandom_range(1, 3), 1'b1);
            end else begin
                drive($urandom_range(0, 7) == 0, $urandom_range(0, 3), $urandom_range(0, 9),
                      $urandom_range(0, 9), $urandom_range(0, 19) == 0);
            end
        end
        idle(4);
        @(negedge sys_clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised clock-enable and divided-clock generator that sits directly behind the board oscillator. It runs entirely on `sys_clk` and derives NUM_CH run-time-programmable divided channels, each with its own divide ratio and phase offset. Each channel provides a one-cycle enable pulse and a square-wave output. The block also produces a lock indication and a gated reset, so downstream logic needs no vendor PLL for low-rate or phase-shifted timing.

## Interface
Parameters:
- `NUM_CH`, 4: number of divider channels (1–16).
- `CNT_W`, 16: width of divide and phase values.
- `DIV_INIT`, 2: divide ratio loaded into every channel at reset.
- `LOCK_CYCLES`, 16: cycles after reset release before `locked` asserts (≥2).

Ports (one clock `sys_clk`; reset `sys_rst_n` is asynchronous, active-low):
- `sys_clk`, in, 1: single clock for all logic.
- `sys_rst_n`, in, 1: async active-low reset for all flops.
- `cfg_wr`, in, 1: one-cycle configuration write strobe.
- `cfg_ch`, in, $clog2(NUM_CH): target channel of the write.
- `cfg_div`, in, CNT_W: divide ratio; 0 disables the channel.
- `cfg_phase`, in, CNT_W: phase offset in sys_clk cycles.
- `sync_start`, in, 1: one-cycle strobe that restarts all channels phase-aligned.
- `cfg_err`, out, 1: one-cycle pulse when a write is rejected.
- `locked`, out, 1: lock window has elapsed; channels are running.
- `rst_out_n`, out, 1: reset for downstream logic; asserts asynchronously and releases synchronously with `locked`.
- `clk_en`, out, NUM_CH: per-channel one-cycle enable pulse.
- `clk_out`, out, NUM_CH: per-channel divided square wave (a data signal, not a clock net).

## Operation
- Reset values:
  - Outputs: `locked`, `rst_out_n`, `cfg_err`, `clk_en` and `clk_out` are all 0.
  - Channel state: every channel has div=DIV_INIT, phase=0 and its counter at 0.
- Lock sequencer has two states, WAIT and LOCKED:
  - WAIT counts sys_clk cycles after reset deassertion.
  - On reaching LOCK_CYCLES it moves to LOCKED.
  - `locked` and `rst_out_n` go to 1 together and stay 1 until the next `sys_rst_n` assertion.
- Channels are held at count 0 with outputs 0 while in WAIT.
- Channel behaviour: let k be the cycle index since the channel last started, with k=0 being the first cycle `locked` reads 1, or the cycle after a restart.
  - `clk_en[i]`=1 exactly when k mod div == phase.
  - `clk_out[i]`=1 when k mod div < (div+1)/2. Odd ratios therefore spend the extra cycle high.
  - div=1: `clk_en`=1 and `clk_out`=1 every cycle.
  - div=0: both outputs are held at 0 and the counter is frozen.
- Counter wrap: the counter runs from 0 to div−1 and returns to 0. It never exceeds div−1.
- Config write: accepted when cfg_phase < cfg_div, or when cfg_div=0 (phase is then ignored and stored as 0).
  - An accepted write updates that channel's div and phase and restarts only that channel (k=0 next cycle).
  - A rejected write pulses `cfg_err` for one cycle and leaves the channel unchanged. Rejection cases are phase ≥ div with div≠0, and cfg_ch ≥ NUM_CH.
- Writes in WAIT: accepted or rejected by the same rules. New values take effect when running starts; no restart occurs until then.
- `sync_start` while LOCKED: every enabled channel restarts with k=0 in the next cycle, so channels with phase 0 pulse in the same cycle.
- `sync_start` in WAIT: ignored.
- Simultaneous `cfg_wr` and `sync_start`: the write is applied and all channels restart together. This is the phase-aligned reprogramming path.
- Reset mid-operation: all state and outputs return to reset values asynchronously, and the lock sequence reruns in full.

## Timing
- `cfg_wr`, `cfg_ch`, `cfg_div`, `cfg_phase` and `sync_start` are sampled on the rising `sys_clk` edge.
- Effects (new ratio, restart, `cfg_err`) are visible in the following cycle.
- `locked` rises LOCK_CYCLES cycles after the first rising edge with `sys_rst_n`=1.
- `clk_en`, `clk_out`, `locked`, `rst_out_n` and `cfg_err` are all registered outputs with no combinational path from inputs.
- Channels do not interact with each other. A write to one channel never disturbs another.

## Structure
- Package `clk_div_pkg` holds:
  - default CNT_W;
  - the lock state encoding (WAIT, LOCKED);
  - a channel configuration struct {div, phase}.
- Sub-module `clk_div_ch`: one instance per channel, generated NUM_CH times. It holds the counter, the config registers, and the enable and square-wave decode.
- The top level holds the lock sequencer, the write decode and validation, and the sync fan-out.

## Test plan
- Reset release with defaults (LOCK_CYCLES=16, DIV_INIT=2): `locked` and `rst_out_n` rise on cycle 16. All `clk_en` then pulse on k=0,2,4… and `clk_out` toggles 1,0,1,0.
- Write ch1 div=5, phase=3: `clk_en[1]` pulses on k=3,8,13; `clk_out[1]` reads 1,1,1,0,0 repeating. Other channels are unaffected.
- Write ch2 div=4, phase=4: `cfg_err` pulses once and ch2 keeps its previous div and phase.
- Program ch0 div=3 and ch3 div=6 (both phase 0), then assert `sync_start`: both channels pulse on the same next cycle and coincide every 6 cycles.
- Write div=0 to ch2, then div=1: ch2 outputs hold at 0, then `clk_en[2]` and `clk_out[2]` read 1 every cycle.
- Assert `sys_rst_n` mid-run, then release: all outputs are 0 immediately, `locked` reasserts after 16 cycles, and every channel is back at div=DIV_INIT.
